note_sequencer: RTL and testbench

- Sits between the tape reader byte output and the tone generator.
- Buffers decoded tape bytes in a small FIFO and plays them back one at a time.
- Each note is held for a duration taken from the byte's 2-bit length code, timed in beat units.
- Handles play/pause, an articulation gap between notes, an end-of-song marker, and overflow/underrun reporting.

---
 rtl/seq_pkg.sv | 31 +++
 rtl/note_fifo.sv | 73 +++++++
 rtl/note_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_note_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the note sequencer: FSM state encoding, the special
// note codes carried in the upper six bits of a tape byte, and the mapping from
// the 2-bit length code to a number of beat units.
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } seq_state_e;

    localparam logic [5:0] NOTE_REST = 6'd0;
    localparam logic [5:0] NOTE_END  = 6'd63;

    // Length code -> beat units: 00=1, 01=2, 10=4, 11=8.
    function automatic logic [3:0] len_units(input logic [1:0] code);
        logic [3:0] units;
        case (code)
            2'b00:   units = 4'd1;
            2'b01:   units = 4'd2;
            2'b10:   units = 4'd4;
            default: units = 4'd8;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/note_fifo.sv
// -----------------------------------------------------------------------------
// note_fifo
// Synchronous show-ahead FIFO. dout always presents the head entry; pop
// advances past it. A push while full is accepted only when a pop happens in
// the same cycle. clr empties the FIFO and discards any same-cycle push.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous flush
//   push, din : write request and data
//   pop       : read request (ignored when empty)
//   dout      : head entry (valid when !empty)
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : number of occupied entries
// -----------------------------------------------------------------------------
module note_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic do_pop;
    logic do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Buffers tape bytes and plays them back one at a time. Each byte holds a
// note for units*BEAT_CYCLES cycles, the last GAP_CYCLES of which are silent,
// plus one FETCH cycle to pop the next entry.
//
// Input handshake: data_change is a one-cycle strobe with no back-pressure;
// data_in is captured on the same clock edge. A byte that finds the FIFO full
// (and no pop in that cycle) is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   data_in      : tape byte, [7:2] note code, [1:0] length code
//   data_change  : byte strobe
//   play         : 1 = run, 0 = pause (timers freeze)
//   note         : note code to the tone generator, 0 = silent
//   note_valid   : a note is sounding
//   song_end     : one-cycle pulse after the end marker is consumed
//   overflow     : sticky, a byte was dropped
//   underrun     : one-cycle pulse when FETCH finds the FIFO empty while playing
//   fifo_count   : FIFO occupancy
//   state        : current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module note_sequencer
    import seq_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int BEAT_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 2500000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_change,
    input  logic                          play,
    output logic [5:0]                    note,
    output logic                          note_valid,
    output logic                          song_end,
    output logic                          overflow,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [1:0]                    state
);

    // Wide enough for the longest note (8 beats) without truncation.
    localparam int CNT_W = $clog2(8 * BEAT_CYCLES + 1);
    localparam logic [CNT_W-1:0] BEAT_W = CNT_W'(BEAT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_W  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] ONE_W  = CNT_W'(1);

    seq_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [5:0]        note_lat_q;
    logic [5:0]        note_q;
    logic              note_valid_q;
    logic              song_end_q;
    logic              overflow_q;
    logic              underrun_q;
    logic              underrun_seen_q;

    logic [7:0]        head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop_w;
    logic              end_hit;
    logic [5:0]        head_note;
    logic [CNT_W-1:0]  hold_load;

    assign head_note = head[7:2];
    assign pop_w     = (state_q == FETCH) && play && !fifo_empty;
    assign end_hit   = pop_w && (head_note == NOTE_END);
    // The gap is carved out of the note's own duration.
    assign hold_load = CNT_W'(len_units(head[1:0])) * BEAT_W - GAP_W;

    note_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (end_hit),
        .push  (data_change),
        .pop   (pop_w),
        .din   (data_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Outputs are registered: a change of play shows on note/note_valid one
    // cycle later, while the counter freezes in the same cycle, so the total
    // number of sounding cycles per note is unaffected by a pause.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            note_lat_q      <= NOTE_REST;
            note_q          <= NOTE_REST;
            note_valid_q    <= 1'b0;
            song_end_q      <= 1'b0;
            overflow_q      <= 1'b0;
            underrun_q      <= 1'b0;
            underrun_seen_q <= 1'b0;
        end else begin
            song_end_q <= 1'b0;
            underrun_q <= 1'b0;

            // A push into a full FIFO survives only if a pop makes room;
            // during a flush the pop is present so nothing is flagged.
            if (data_change && fifo_full && !pop_w) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    note_q          <= NOTE_REST;
                    note_valid_q    <= 1'b0;
                    underrun_seen_q <= 1'b0;
                    if (play && !fifo_empty) begin
                        state_q <= FETCH;
                    end
                end

                FETCH: begin
                    note_q       <= NOTE_REST;
                    note_valid_q <= 1'b0;
                    if (play) begin
                        if (fifo_empty) begin
                            // Report only once per visit to FETCH.
                            if (!underrun_seen_q) begin
                                underrun_q <= 1'b1;
                            end
                            underrun_seen_q <= 1'b1;
                        end else if (head_note == NOTE_END) begin
                            song_end_q      <= 1'b1;
                            underrun_seen_q <= 1'b0;
                            state_q         <= IDLE;
                        end else begin
                            note_lat_q      <= head_note;
                            cnt_q           <= hold_load;
                            note_q          <= head_note;
                            note_valid_q    <= (head_note != NOTE_REST);
                            underrun_seen_q <= 1'b0;
                            state_q         <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (play) begin
                        if (cnt_q == ONE_W) begin
                            cnt_q        <= GAP_W;
                            note_q       <= NOTE_REST;
                            note_valid_q <= 1'b0;
                            state_q      <= GAP;
                        end else begin
                            cnt_q        <= cnt_q - ONE_W;
                            note_q       <= note_lat_q;
                            note_valid_q <= (note_lat_q != NOTE_REST);
                        end
                    end else begin
                        note_q       <= NOTE_REST;
                        note_valid_q <= 1'b0;
                    end
                end

                GAP: begin
                    note_q       <= NOTE_REST;
                    note_valid_q <= 1'b0;
                    if (play) begin
                        if (cnt_q == ONE_W) begin
                            state_q <= FETCH;
                        end else begin
                            cnt_q <= cnt_q - ONE_W;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign note       = note_q;
    assign note_valid = note_valid_q;
    assign song_end   = song_end_q;
    assign overflow   = overflow_q;
    assign underrun   = underrun_q;
    assign state      = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
// Directed bench for note_sequencer with BEAT_CYCLES=10, GAP_CYCLES=2,
// FIFO_DEPTH=8. Expected notes are queued as {note, sounding_cycles} when the
// byte is pushed; a monitor closes each note when the FSM moves HOLD -> GAP
// and compares against the head of the queue.
// -----------------------------------------------------------------------------
module tb_note_sequencer;
    import seq_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       data_change;
    logic       play;
    logic [5:0] note;
    logic       note_valid;
    logic       song_end;
    logic       overflow;
    logic       underrun;
    logic [3:0] fifo_count;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    logic [13:0] exp_q[$];

    note_sequencer #(
        .FIFO_DEPTH  (8),
        .BEAT_CYCLES (10),
        .GAP_CYCLES  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_change (data_change),
        .play        (play),
        .note        (note),
        .note_valid  (note_valid),
        .song_end    (song_end),
        .overflow    (overflow),
        .underrun    (underrun),
        .fifo_count  (fifo_count),
        .state       (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        data_in     = b;
        data_change = 1'b1;
        step(1);
        data_change = 1'b0;
    endtask

    task automatic expect_note(input logic [5:0] n, input logic [7:0] cycles);
        exp_q.push_back({n, cycles});
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            step(1);
            n++;
        end
        chk(nm, 32'(state), 32'(s));
    endtask

    // sel 0 = underrun, 1 = song_end
    task automatic wait_pulse(input int sel, input int budget, input string nm);
        int n;
        logic sig;
        n = 0;
        sig = (sel == 0) ? underrun : song_end;
        while (sig !== 1'b1 && n < budget) begin
            step(1);
            n++;
            sig = (sel == 0) ? underrun : song_end;
        end
        chk(nm, 32'(sig), 32'd1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [1:0]  prev_state = 2'd0;
    int          acc        = 0;
    logic [5:0]  last_note  = 6'd0;
    logic [13:0] exp_e;

    always @(negedge clk) begin
        if (rst) begin
            acc       = 0;
            last_note = 6'd0;
        end else begin
            if (note_valid) begin
                acc++;
                last_note = note;
            end
            if (state == GAP && prev_state == HOLD) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL note_unexpected: got note %0d for %0d cycles want none", last_note, acc);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({last_note, 8'(acc)} !== exp_e) begin
                        bad++;
                        $display("FAIL note_played: got note %0d for %0d cycles want note %0d for %0d cycles",
                                 last_note, acc, exp_e[13:8], exp_e[7:0]);
                    end
                end
                acc       = 0;
                last_note = 6'd0;
            end
        end
        prev_state = state;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b1;
        data_in     = 8'h00;
        data_change = 1'b0;
        play        = 1'b0;
        step(3);
        chk("rst_note", 32'(note), 32'd0);
        chk("rst_valid", 32'(note_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_state", 32'(state), 32'(IDLE));
        rst = 1'b0;
        step(1);

        // Single note 57, length 8 beats: 78 sounding + 2 gap cycles.
        push_byte(8'hE7);
        chk("single_count", 32'(fifo_count), 32'd1);
        expect_note(6'd57, 8'd78);
        play = 1'b1;
        wait_state(GAP, 200, "single_reach_gap");
        chk("single_gap_note", 32'(note), 32'd0);
        step(1);
        chk("single_gap2_state", 32'(state), 32'(GAP));
        step(1);
        chk("single_fetch_state", 32'(state), 32'(FETCH));
        step(1);
        chk("single_underrun", 32'(underrun), 32'd1);
        step(1);
        chk("single_underrun_once", 32'(underrun), 32'd0);

        // Overflow: 9 pushes while paused, 9th is dropped.
        play = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            push_byte(8'(i << 2));
            if (i <= 8) expect_note(6'(i), 8'd8);
        end
        chk("ovf_count", 32'(fifo_count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        play = 1'b1;
        wait_pulse(0, 250, "ovf_drain_underrun");
        chk("ovf_all_played", 32'(exp_q.size()), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO, push coincides with the FETCH pop.
        rst = 1'b1;
        play = 1'b0;
        step(1);
        rst = 1'b0;
        chk("full_ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 10; i <= 17; i++) begin
            push_byte(8'(i << 2));
            expect_note(6'(i), 8'd8);
        end
        chk("full_count", 32'(fifo_count), 32'd8);
        play = 1'b1;
        step(1);
        chk("full_in_fetch", 32'(state), 32'(FETCH));
        push_byte(8'(18 << 2));
        expect_note(6'd18, 8'd8);
        chk("full_pushpop_count", 32'(fifo_count), 32'd8);
        chk("full_pushpop_ovf", 32'(overflow), 32'd0);
        wait_pulse(0, 300, "full_drain_underrun");
        chk("full_all_played", 32'(exp_q.size()), 32'd0);

        // Pause mid-note: 18 sounding cycles total regardless of the pause.
        push_byte(8'h05);
        expect_note(6'd1, 8'd18);
        wait_state(HOLD, 10, "pause_reach_hold");
        step(5);
        play = 1'b0;
        step(10);
        chk("pause_note", 32'(note), 32'd0);
        chk("pause_valid", 32'(note_valid), 32'd0);
        chk("pause_state", 32'(state), 32'(HOLD));
        step(10);
        play = 1'b1;
        step(2);
        chk("resume_note", 32'(note), 32'd1);
        wait_state(GAP, 30, "pause_reach_gap");
        step(1);

        // Reset while a note is sounding.
        push_byte(8'hE7);
        wait_state(HOLD, 20, "midrst_reach_hold");
        step(10);
        push_byte(8'h10);
        rst = 1'b1;
        step(3);
        chk("midrst_note", 32'(note), 32'd0);
        chk("midrst_valid", 32'(note_valid), 32'd0);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        chk("midrst_state", 32'(state), 32'(IDLE));
        rst  = 1'b0;
        play = 1'b0;
        step(2);
        chk("midrst_idle", 32'(state), 32'(IDLE));

        // End marker: note 2 plays, marker flushes the trailing byte.
        push_byte(8'h08);
        push_byte(8'hFC);
        push_byte(8'h0C);
        chk("end_count", 32'(fifo_count), 32'd3);
        expect_note(6'd2, 8'd8);
        play = 1'b1;
        wait_pulse(1, 60, "end_song_end");
        chk("end_flushed", 32'(fifo_count), 32'd0);
        chk("end_state", 32'(state), 32'(IDLE));
        step(1);
        chk("end_pulse_once", 32'(song_end), 32'd0);
        step(20);
        chk("end_stays_idle", 32'(state), 32'(IDLE));
        chk("end_silent", 32'(note_valid), 32'd0);
        chk("end_no_ovf", 32'(overflow), 32'd0);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
